// File: rtl/tb_sim_ctrl.sv
// Simulation control block: holds the core in reset-fetch, runs it, and records the first
// pass/fail/exit/timeout event as a sticky status after a drain window.
module tb_sim_ctrl #(
   parameter int HOLD_CYCLES  = 4,
   parameter int DRAIN_CYCLES = 8,
   parameter int CNT_WIDTH    = 32
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        fetch_enable_o,
   output logic        tests_passed_o,
   output logic        tests_failed_o,
   output logic        exit_valid_o,
   output logic [31:0] exit_value_o,
   output logic        timeout_o
);

   localparam logic [1:0] ST_HOLD  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [1:0] K_PASS    = 2'd0;
   localparam logic [1:0] K_FAIL    = 2'd1;
   localparam logic [1:0] K_EXIT    = 2'd2;
   localparam logic [1:0] K_TIMEOUT = 2'd3;

   localparam logic [2:0] R_PASS  = 3'd0;
   localparam logic [2:0] R_FAIL  = 3'd1;
   localparam logic [2:0] R_EXIT  = 3'd2;
   localparam logic [2:0] R_MAX   = 3'd3;
   localparam logic [2:0] R_CYCLE = 3'd4;

   localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

   logic [1:0]           state_q, state_d;
   logic [1:0]           kind_q, kind_d;
   logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
   logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
   logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_WIDTH-1:0] max_q, max_d;
   logic [31:0]          exit_q, exit_d;
   logic                 rvalid_q, rvalid_d;
   logic [31:0]          rdata_q, rdata_d;

   logic [31:0] be_mask;
   logic [2:0]  reg_sel;
   logic        wr_req;
   logic        rd_req;
   logic        term_wr;
   logic        timeout_hit;
   logic        unused_addr;

   for (genvar gi = 0; gi < 4; gi++) begin : g_be_mask
      assign be_mask[gi*8 +: 8] = {8{be_i[gi]}};
   end

   assign reg_sel     = addr_i[4:2];
   assign wr_req      = req_i & we_i;
   assign rd_req      = req_i & ~we_i;
   assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};

   assign term_wr     = (state_q == ST_RUN) && wr_req && (|be_i) && (reg_sel <= R_EXIT);
   assign timeout_hit = (state_q == ST_RUN) && (max_q != '0) && (cycle_cnt_q >= max_q);

   always_comb begin
      state_d     = state_q;
      kind_d      = kind_q;
      hold_cnt_d  = hold_cnt_q;
      drain_cnt_d = drain_cnt_q;
      cycle_cnt_d = cycle_cnt_q;
      max_d       = max_q;
      exit_d      = exit_q;
      rvalid_d    = req_i;
      rdata_d     = '0;

      case (state_q)
         ST_HOLD: begin
            cycle_cnt_d = '0;
            if ((HOLD_CYCLES == 0) || (hold_cnt_q == HOLD_LAST)) begin
               state_d = ST_RUN;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            // The counter freezes on the terminating cycle so a timeout reads back as MAXCYCLES.
            if (term_wr || timeout_hit) begin
               drain_cnt_d = '0;
               state_d     = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
               if (term_wr) begin
                  case (reg_sel)
                     R_PASS:  kind_d = K_PASS;
                     R_FAIL:  kind_d = K_FAIL;
                     default: begin
                        kind_d = K_EXIT;
                        exit_d = (exit_q & ~be_mask) | (wdata_i & be_mask);
                     end
                  endcase
               end else begin
                  kind_d = K_TIMEOUT;
               end
            end else if (cycle_cnt_q != '1) begin
               cycle_cnt_d = cycle_cnt_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d = ST_DONE;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end
         default: ;
      endcase

      if (wr_req && (reg_sel == R_MAX) && (state_q != ST_HOLD)) begin
         max_d = (max_q & ~be_mask[CNT_WIDTH-1:0]) | (wdata_i[CNT_WIDTH-1:0] & be_mask[CNT_WIDTH-1:0]);
      end

      if (rd_req) begin
         case (reg_sel)
            R_MAX:   rdata_d = 32'(max_q);
            R_CYCLE: rdata_d = 32'(cycle_cnt_q);
            default: rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= ST_HOLD;
         kind_q      <= K_PASS;
         hold_cnt_q  <= '0;
         drain_cnt_q <= '0;
         cycle_cnt_q <= '0;
         max_q       <= '0;
         exit_q      <= '0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         kind_q      <= kind_d;
         hold_cnt_q  <= hold_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         cycle_cnt_q <= cycle_cnt_d;
         max_q       <= max_d;
         exit_q      <= exit_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
      end
   end

   assign gnt_o          = req_i;
   assign rvalid_o       = rvalid_q;
   assign rdata_o        = rdata_q;
   assign fetch_enable_o = (state_q == ST_RUN);
   assign tests_passed_o = (state_q == ST_DONE) && (kind_q == K_PASS);
   assign tests_failed_o = (state_q == ST_DONE) && (kind_q == K_FAIL);
   assign exit_valid_o   = (state_q == ST_DONE) && (kind_q == K_EXIT);
   assign timeout_o      = (state_q == ST_DONE) && (kind_q == K_TIMEOUT);
   assign exit_value_o   = exit_q;

endmodule

// File: tb/tb_tb_sim_ctrl.sv
// Directed bench for tb_sim_ctrl: hold/run sequencing, register access, each terminating
// event kind, write-vs-timeout priority and reset in the middle of the drain window.
module tb_tb_sim_ctrl;

   localparam logic [31:0] A_PASS = 32'h00;
   localparam logic [31:0] A_FAIL = 32'h04;
   localparam logic [31:0] A_EXIT = 32'h08;
   localparam logic [31:0] A_MAX  = 32'h0C;
   localparam logic [31:0] A_CYC  = 32'h10;
   localparam logic [31:0] A_RSVD = 32'h14;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [3:0]  be_i;
   logic [31:0] wdata_i;
   logic        gnt_o;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        fetch_enable_o;
   logic        tests_passed_o;
   logic        tests_failed_o;
   logic        exit_valid_o;
   logic [31:0] exit_value_o;
   logic        timeout_o;
   logic [3:0]  status;

   int tests  = 0;
   int failed = 0;
   logic [31:0] rd;

   always #5 clk_i = ~clk_i;

   tb_sim_ctrl #(
      .HOLD_CYCLES(4),
      .DRAIN_CYCLES(8),
      .CNT_WIDTH(32)
   ) dut (
      .clk_i(clk_i),
      .rst_ni(rst_ni),
      .req_i(req_i),
      .we_i(we_i),
      .addr_i(addr_i),
      .be_i(be_i),
      .wdata_i(wdata_i),
      .gnt_o(gnt_o),
      .rvalid_o(rvalid_o),
      .rdata_o(rdata_o),
      .fetch_enable_o(fetch_enable_o),
      .tests_passed_o(tests_passed_o),
      .tests_failed_o(tests_failed_o),
      .exit_valid_o(exit_valid_o),
      .exit_value_o(exit_value_o),
      .timeout_o(timeout_o)
   );

   // {passed, failed, exit_valid, timeout}
   assign status = {tests_passed_o, tests_failed_o, exit_valid_o, timeout_o};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
      req_i   = 1'b1;
      we_i    = 1'b1;
      addr_i  = addr;
      be_i    = be;
      wdata_i = data;
      #1;
      chk("wr_gnt", 32'(gnt_o), 32'd1);
      step();
      chk("wr_rvalid", 32'(rvalid_o), 32'd1);
      chk("wr_rdata", rdata_o, 32'd0);
      req_i   = 1'b0;
      we_i    = 1'b0;
      be_i    = 4'h0;
      wdata_i = 32'h0;
      $display("[TB] write addr=%h be=%b data=%h", addr, be, data);
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
      req_i  = 1'b1;
      we_i   = 1'b0;
      addr_i = addr;
      be_i   = 4'hF;
      #1;
      chk("rd_gnt", 32'(gnt_o), 32'd1);
      step();
      chk("rd_rvalid", 32'(rvalid_o), 32'd1);
      data   = rdata_o;
      req_i  = 1'b0;
      be_i   = 4'h0;
      $display("[TB] read  addr=%h data=%h", addr, data);
   endtask

   // Reset, then release and wait out the four hold cycles so the DUT is in RUN with CYCLE=0.
   task automatic do_reset();
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
      repeat (4) step();
   endtask

   initial begin
      rst_ni  = 1'b0;
      req_i   = 1'b0;
      we_i    = 1'b0;
      addr_i  = 32'h0;
      be_i    = 4'h0;
      wdata_i = 32'h0;

      // Reset state
      step();
      step();
      chk("rst_fetch", 32'(fetch_enable_o), 32'd0);
      chk("rst_status", 32'(status), 32'd0);
      chk("rst_rvalid", 32'(rvalid_o), 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      chk("rst_exit_value", exit_value_o, 32'd0);
      req_i  = 1'b1;
      addr_i = 32'h1C;
      #1;
      chk("gnt_comb_hi", 32'(gnt_o), 32'd1);
      req_i = 1'b0;
      #1;
      chk("gnt_comb_lo", 32'(gnt_o), 32'd0);

      // Hold window then RUN; CYCLE counts RUN cycles
      rst_ni = 1'b1;
      repeat (3) step();
      chk("hold_fetch_c3", 32'(fetch_enable_o), 32'd0);
      step();
      chk("run_fetch_c4", 32'(fetch_enable_o), 32'd1);
      repeat (5) step();
      bus_read(A_CYC, rd);
      chk("cycle_read_5", rd, 32'd5);
      step();
      chk("idle_rvalid", 32'(rvalid_o), 32'd0);
      chk("idle_rdata", rdata_o, 32'd0);

      // PASS write -> drain 8 cycles -> DONE
      bus_write(A_PASS, 4'hF, 32'h1);
      chk("drain_fetch", 32'(fetch_enable_o), 32'd0);
      chk("drain_status", 32'(status), 32'd0);
      repeat (7) step();
      chk("pass_early", 32'(status), 32'd0);
      step();
      chk("pass_done", 32'(status), 32'h8);
      chk("done_fetch", 32'(fetch_enable_o), 32'd0);

      // EXIT with partial byte enables; later FAIL write ignored
      do_reset();
      chk("exit_run_fetch", 32'(fetch_enable_o), 32'd1);
      bus_write(A_EXIT, 4'b0011, 32'hDEAD_BEEF);
      chk("exit_value_be", exit_value_o, 32'h0000_BEEF);
      bus_write(A_FAIL, 4'hF, 32'h1);
      repeat (7) step();
      chk("exit_done", 32'(status), 32'h2);
      bus_write(A_EXIT, 4'hF, 32'h1234_5678);
      chk("exit_value_final", exit_value_o, 32'h0000_BEEF);
      chk("exit_status_final", 32'(status), 32'h2);

      // Timeout at MAXCYCLES=100
      do_reset();
      chk("rst_exit_cleared", exit_value_o, 32'd0);
      bus_write(A_MAX, 4'hF, 32'd100);
      bus_read(A_MAX, rd);
      chk("max_read_100", rd, 32'd100);
      repeat (106) step();
      chk("timeout_early", 32'(status), 32'd0);
      step();
      chk("timeout_done", 32'(status), 32'h1);
      bus_read(A_CYC, rd);
      chk("timeout_cycle_100", rd, 32'd100);
      bus_read(A_RSVD, rd);
      chk("rsvd_read_0", rd, 32'd0);
      bus_read(A_PASS, rd);
      chk("pass_reg_read_0", rd, 32'd0);
      bus_write(A_MAX, 4'b0010, 32'h0000_1200);
      bus_read(A_MAX, rd);
      chk("max_byte_write", rd, 32'h0000_1264);

      // FAIL write in the same cycle the counter reaches MAXCYCLES: write wins
      do_reset();
      bus_write(A_MAX, 4'hF, 32'd20);
      repeat (19) step();
      bus_write(A_FAIL, 4'hF, 32'h1);
      repeat (8) step();
      chk("fail_beats_timeout", 32'(status), 32'h4);

      // MAXCYCLES ignored in HOLD, then reset in the middle of DRAIN
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
      bus_write(A_MAX, 4'hF, 32'd7);
      repeat (3) step();
      chk("hold_wr_run", 32'(fetch_enable_o), 32'd1);
      bus_read(A_MAX, rd);
      chk("hold_wr_ignored", rd, 32'd0);
      bus_write(A_MAX, 4'hF, 32'h33);
      bus_write(A_PASS, 4'hF, 32'h1);
      repeat (3) step();
      rst_ni = 1'b0;
      req_i  = 1'b1;
      we_i   = 1'b0;
      addr_i = A_MAX;
      step();
      chk("mid_rst_rvalid", 32'(rvalid_o), 32'd0);
      chk("mid_rst_rdata", rdata_o, 32'd0);
      chk("mid_rst_status", 32'(status), 32'd0);
      chk("mid_rst_fetch", 32'(fetch_enable_o), 32'd0);
      req_i  = 1'b0;
      rst_ni = 1'b1;
      repeat (4) step();
      chk("post_rst_run", 32'(fetch_enable_o), 32'd1);
      bus_read(A_MAX, rd);
      chk("post_rst_max_0", rd, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/tb_sim_ctrl.md
TB_SIM_CTRL -- requirements
Module: tb_sim_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, cycles fetch_enable_o stays low after reset release.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 8, cycles between a terminating event and status assertion.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, width of the cycle counter and MAXCYCLES register.
REQ-004 SHALL have one clock; reset is synchronous and active-low.
REQ-005 SHALL have port clk_i input 1: clock, all state updates on rising edge.
REQ-006 SHALL have port rst_ni input 1: synchronous active-low reset.
REQ-007 SHALL have port req_i input 1: bus request.
REQ-008 SHALL have port we_i input 1: write enable.
REQ-009 SHALL have port addr_i input 32: byte address; only bits [4:2] decoded.
REQ-010 SHALL have port be_i input 4: byte enables.
REQ-011 SHALL have port wdata_i input 32: write data.
REQ-012 SHALL have port gnt_o output 1: grant.
REQ-013 SHALL have port rvalid_o output 1: response valid.
REQ-014 SHALL have port rdata_o output 32: read data.
REQ-015 SHALL have port fetch_enable_o output 1: core fetch enable.
REQ-016 SHALL have port tests_passed_o output 1: pass status.
REQ-017 SHALL have port tests_failed_o output 1: fail status.
REQ-018 SHALL have port exit_valid_o output 1: exit status valid.
REQ-019 SHALL have port exit_value_o output 32: exit code.
REQ-020 SHALL have port timeout_o output 1: cycle limit reached.

Function
REQ-021 SHALL implement states HOLD, RUN, DRAIN, DONE; reset enters HOLD.
REQ-022 HOLD: hold counter counts 0..HOLD_CYCLES-1, then RUN; fetch_enable_o=0 in HOLD, 1 only in RUN.
REQ-023 SHALL assert gnt_o = req_i combinationally in every state; rvalid_o=1 exactly one cycle after each granted request.
REQ-024 Register map by addr_i[4:2]: 0 PASS (WO), 1 FAIL (WO), 2 EXIT (WO), 3 MAXCYCLES (RW), 4 CYCLE (RO); others read 0, writes ignored.
REQ-025 rdata_o SHALL carry read value in rvalid cycle, 0 for writes and when rvalid_o=0.
REQ-026 Write to PASS/FAIL/EXIT with be_i!=0 in RUN SHALL be a terminating event recording kind (pass/fail/exit); EXIT latches wdata_i per byte enable into exit value.
REQ-027 MAXCYCLES write SHALL update only enabled bytes (low CNT_WIDTH bits); accepted in any state except HOLD.
REQ-028 Cycle counter SHALL clear in HOLD, increment by 1 each RUN cycle, saturate at all-ones, freeze outside RUN.
REQ-029 In RUN, MAXCYCLES!=0 and counter >= MAXCYCLES SHALL be a timeout terminating event; MAXCYCLES=0 disables timeout.
REQ-030 Simultaneous write terminating event and timeout: write wins, timeout not recorded.
REQ-031 Terminating event: RUN -> DRAIN next cycle; drain counter counts DRAIN_CYCLES cycles, then DONE.
REQ-032 In DRAIN/DONE, PASS/FAIL/EXIT writes SHALL be granted and acknowledged but ignored; first event is final.
REQ-033 In DONE exactly one of tests_passed_o, tests_failed_o, exit_valid_o, timeout_o SHALL be 1, held until reset; all 0 in HOLD/RUN/DRAIN.
REQ-034 exit_value_o SHALL show latched exit value at all times (0 after reset).
REQ-035 DRAIN_CYCLES=0 SHALL go RUN -> DONE directly; HOLD_CYCLES=0 SHALL go HOLD -> RUN after one cycle.

Reset
REQ-036 rst_ni=0 at a rising edge SHALL, in any state including mid-DRAIN, set state HOLD, all outputs 0, counters 0, MAXCYCLES 0, exit value 0, pending rvalid dropped.

Verification
REQ-037 Reset release, HOLD_CYCLES=4 -> fetch_enable_o rises 4 cycles after first cycle with rst_ni=1; read CYCLE returns elapsed RUN cycles.
REQ-038 Write PASS (be=4'hF, wdata=1) in RUN -> gnt_o same cycle, rvalid_o next, tests_passed_o=1 after DRAIN_CYCLES+1 cycles, fetch_enable_o=0 from DRAIN onward.
REQ-039 Write EXIT be=4'b0011 wdata=32'hDEAD_BEEF -> exit_value_o=32'h0000_BEEF, exit_valid_o=1 in DONE; later FAIL write -> tests_failed_o stays 0.
REQ-040 MAXCYCLES=100, no writes -> timeout_o=1 in DONE; CYCLE read =100.
REQ-041 FAIL write same cycle counter reaches MAXCYCLES -> tests_failed_o=1, timeout_o=0.
REQ-042 rst_ni=0 during DRAIN -> next cycle all status 0, state HOLD, MAXCYCLES read 0.
